// File: rtl/udp_tx_scheduler.sv
// -----------------------------------------------------------------------------
// udp_tx_scheduler
//
// Shares a single UDP encoder among N_REQ transmit requesters (sockets) with
// round-robin arbitration. For each packet the block:
//   1. picks a winner among the raised req bits (IDLE, 1 cycle),
//   2. latches the winner's header configuration and pulses enc_start (START),
//   3. forwards only the winner's payload stream to the encoder (STREAM),
//   4. captures checksum/length on enc_fin, or aborts after TIMEOUT cycles,
//   5. pulses enc_reset for one cycle so the encoder is clean for the next
//      packet (CLEAR).
// The encoder's own output stream (wr_en/pkg_data) bypasses this block.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   req                 per-requester transmit request (level, held until
//                       done/err)
//   req_src_ip,
//   req_dest_ip         packed 32-bit per requester, slice i = [32i+31:32i]
//   req_src_port,
//   req_dest_port,
//   req_len             packed 16-bit per requester
//   req_no_chksum       per-requester checksum disable
//   req_data,
//   req_data_av         per-requester payload word and its valid
//   grant               one-hot, high from START through CLEAR
//   done                one-hot, 1-cycle pulse when the encoder finished
//   err                 one-hot, 1-cycle pulse when the transaction timed out
//   res_checksum,
//   res_len             results captured from the encoder at fin
//   enc_src_ip .. enc_no_chksum
//                       latched header config, stable START..CLEAR
//   enc_start           1-cycle start pulse to the encoder
//   enc_data,
//   enc_data_av         winner's payload, forwarded in START and STREAM only
//   enc_reset           encoder reset: block reset or CLEAR state
//   enc_fin,
//   enc_checksum,
//   enc_len             encoder completion and results
// -----------------------------------------------------------------------------
module udp_tx_scheduler #(
  parameter int N_REQ   = 4,
  parameter int IDX_W   = 2,
  parameter int TIMEOUT = 4096
) (
  input  logic                 clk,
  input  logic                 reset,

  input  logic [N_REQ-1:0]     req,
  input  logic [32*N_REQ-1:0]  req_src_ip,
  input  logic [32*N_REQ-1:0]  req_dest_ip,
  input  logic [16*N_REQ-1:0]  req_src_port,
  input  logic [16*N_REQ-1:0]  req_dest_port,
  input  logic [16*N_REQ-1:0]  req_len,
  input  logic [N_REQ-1:0]     req_no_chksum,
  input  logic [32*N_REQ-1:0]  req_data,
  input  logic [N_REQ-1:0]     req_data_av,

  output logic [N_REQ-1:0]     grant,
  output logic [N_REQ-1:0]     done,
  output logic [N_REQ-1:0]     err,
  output logic [15:0]          res_checksum,
  output logic [15:0]          res_len,

  output logic [31:0]          enc_src_ip,
  output logic [31:0]          enc_dest_ip,
  output logic [15:0]          enc_src_port,
  output logic [15:0]          enc_dest_port,
  output logic [15:0]          enc_len_in,
  output logic                 enc_no_chksum,
  output logic                 enc_start,
  output logic                 enc_data_av,
  output logic [31:0]          enc_data,
  output logic                 enc_reset,

  input  logic                 enc_fin,
  input  logic [15:0]          enc_checksum,
  input  logic [15:0]          enc_len
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_STREAM,
    S_CLEAR
  } state_t;

  state_t               state;
  state_t               next_state;

  logic [IDX_W-1:0]     rr_ptr;     // index of the most recent winner
  logic [IDX_W-1:0]     win_idx;    // index of the current transaction owner
  logic [CNT_W-1:0]     cnt;        // STREAM cycle counter

  logic                 arb_found;
  logic [IDX_W-1:0]     arb_idx;
  logic [N_REQ-1:0]     arb_onehot;
  logic [IDX_W-1:0]     cand_idx;
  logic                 cnt_at_limit;

  assign cnt_at_limit = (cnt == CNT_W'(TIMEOUT - 1));

  // ---------------------------------------------------------------------------
  // Round-robin arbiter: scan rr_ptr+1, rr_ptr+2, ... (mod N_REQ) and take the
  // first raised request, so the last winner ends up with lowest priority.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    arb_found  = 1'b0;
    arb_idx    = '0;
    arb_onehot = '0;
    cand_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand_idx = IDX_W'((int'(rr_ptr) + k) % N_REQ);
      if (!arb_found && req[cand_idx]) begin
        arb_found = 1'b1;
        arb_idx   = cand_idx;
      end
    end
    arb_onehot[arb_idx] = arb_found;
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (arb_found) next_state = S_START;
      S_START:  next_state = S_STREAM;
      S_STREAM: if (enc_fin || cnt_at_limit) next_state = S_CLEAR;
      S_CLEAR:  next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: combinational outputs
  // enc_reset follows the block reset directly so the encoder is held in
  // reset in the same cycle, and is also asserted for the whole CLEAR cycle.
  // The payload path is a pure mux on the latched winner; other requesters'
  // data_av is simply never selected.
  // ---------------------------------------------------------------------------
  always_comb begin
    enc_start   = 1'b0;
    enc_data_av = 1'b0;
    enc_data    = '0;
    enc_reset   = reset;
    case (state)
      S_START: begin
        enc_start   = 1'b1;
        enc_data    = req_data[32*win_idx +: 32];
        enc_data_av = req_data_av[win_idx];
      end
      S_STREAM: begin
        enc_data    = req_data[32*win_idx +: 32];
        enc_data_av = req_data_av[win_idx];
      end
      S_CLEAR: begin
        enc_reset   = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: arbitration pointer, grant/done/err, header config, timeout
  // counter and captured results.
  // done and err are registered so they appear during CLEAR, i.e. the cycle
  // after fin or after the final timed-out STREAM cycle; grant is still high
  // then, so the pulses simply copy it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr        <= IDX_W'(N_REQ - 1);   // index 0 wins first after reset
      win_idx       <= '0;
      cnt           <= '0;
      grant         <= '0;
      done          <= '0;
      err           <= '0;
      res_checksum  <= '0;
      res_len       <= '0;
      enc_src_ip    <= '0;
      enc_dest_ip   <= '0;
      enc_src_port  <= '0;
      enc_dest_port <= '0;
      enc_len_in    <= '0;
      enc_no_chksum <= 1'b0;
    end else begin
      done <= '0;
      err  <= '0;
      case (state)
        S_IDLE: begin
          if (arb_found) begin
            // Header config is frozen here; the requester may change its
            // inputs afterwards without disturbing the packet in flight.
            enc_src_ip    <= req_src_ip[32*arb_idx +: 32];
            enc_dest_ip   <= req_dest_ip[32*arb_idx +: 32];
            enc_src_port  <= req_src_port[16*arb_idx +: 16];
            enc_dest_port <= req_dest_port[16*arb_idx +: 16];
            enc_len_in    <= req_len[16*arb_idx +: 16];
            enc_no_chksum <= req_no_chksum[arb_idx];
            grant         <= arb_onehot;
            rr_ptr        <= arb_idx;
            win_idx       <= arb_idx;
            cnt           <= '0;
          end
        end
        S_STREAM: begin
          cnt <= cnt + 1'b1;
          if (enc_fin) begin
            // fin takes precedence over a coincident timeout
            res_checksum <= enc_checksum;
            res_len      <= enc_len;
            done         <= grant;
          end else if (cnt_at_limit) begin
            err          <= grant;
          end
        end
        S_CLEAR: begin
          grant <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/udp_tx_scheduler.md
Name: udp_tx_scheduler

Overview:
- Shares one UDP encoder instance among N_REQ transmit requesters (sockets) using round-robin arbitration.
- Per transaction: latches the winner's header config, pulses the encoder start, and forwards only the winner's payload stream.
- Waits for the encoder's fin, captures checksum and UDP length, then issues a one-cycle encoder clear so the encoder is ready for the next packet.
- Sits between the socket layer and the encoder; the encoder's wr_en/pkg_data go straight to the IP framer, not through this block.

Parameters:
- N_REQ, 4, number of requesters.
- IDX_W, 2, width of the requester index; must satisfy 2^IDX_W >= N_REQ.
- TIMEOUT, 4096, maximum cycles in STREAM before the transaction is aborted.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req  in  N_REQ  per-requester transmit request (level)
- req_src_ip  in  32*N_REQ  source IP, slice i = [32i+31:32i]
- req_dest_ip  in  32*N_REQ  destination IP
- req_src_port  in  16*N_REQ  source port
- req_dest_port  in  16*N_REQ  destination port
- req_len  in  16*N_REQ  payload length in bytes
- req_no_chksum  in  N_REQ  checksum disable
- req_data  in  32*N_REQ  payload word
- req_data_av  in  N_REQ  payload word valid
- grant  out  N_REQ  one-hot, high START..CLEAR inclusive
- done  out  N_REQ  one-hot, 1-cycle pulse on completion
- err  out  N_REQ  one-hot, 1-cycle pulse on timeout abort
- res_checksum  out  16  captured enc_checksum
- res_len  out  16  captured enc_len
- enc_src_ip, enc_dest_ip  out  32  to encoder
- enc_src_port, enc_dest_port, enc_len_in  out  16  to encoder
- enc_no_chksum, enc_start, enc_data_av  out  1  to encoder
- enc_data  out  32  to encoder
- enc_reset  out  1  encoder reset
- enc_fin  in  1  encoder fin
- enc_checksum  in  16  encoder checksum_out
- enc_len  in  16  encoder len_out

Behaviour:
- Reset (reset sampled high on a clk edge): state=IDLE; grant, done, err, enc_start, enc_data_av, res_checksum, res_len and all config registers = 0; rr_ptr = N_REQ-1, so index 0 has first priority.
- enc_reset = reset OR (state==CLEAR), combinational.
- Reset mid-transaction abandons the packet immediately; no done or err is issued.
- IDLE:
  - If req != 0, select the first set bit scanning rr_ptr+1, rr_ptr+2, ... modulo N_REQ.
  - Latch that requester's src_ip, dest_ip, src_port, dest_port, len and no_chksum into config registers.
  - Set grant one-hot, set rr_ptr = winner, go to START. Arbitration therefore costs 1 cycle.
  - If req == 0, stay in IDLE.
- START (exactly 1 cycle): enc_start=1 → STREAM.
- STREAM: hold enc_start=0 and count cycles.
  - If enc_fin=1: res_checksum<=enc_checksum, res_len<=enc_len, done[winner] pulses for 1 cycle → CLEAR.
  - Else if the counter reaches TIMEOUT-1: err[winner] pulses for 1 cycle, results unchanged → CLEAR.
  - If fin and timeout occur in the same cycle, fin wins.
- CLEAR (1 cycle): enc_reset=1, grant drops at the end of the cycle → IDLE. Back-to-back packets therefore have a 2-cycle gap, CLEAR plus IDLE.
- enc_* config outputs are driven from the config registers, which stay stable START..CLEAR; later requester changes have no effect. The encoder computes its checksum from these live inputs at fin.
- Data forwarding:
  - enc_data = req_data[winner] and enc_data_av = req_data_av[winner], combinational, in START and STREAM only.
  - Otherwise enc_data_av=0 and enc_data=0.
  - Non-granted requesters' data_av is ignored; no buffering.
- Requester protocol:
  - Hold req until its done or err pulse.
  - req deasserting after grant is ignored; the transaction completes.
  - req still high after done makes the requester eligible again but lowest priority (round-robin).
- N_REQ=1 degenerates to a sequencer with no arbitration. req_len=0 is legal; the encoder produces its fin after the header words.
- Counter width is clog2(TIMEOUT) and it is cleared on entry to START.

Test Plan:
- Single request: req=4'b0001, len=8, two data words with data_av=1 on consecutive cycles -> enc_start pulses 1 cycle after req; done=4'b0001 the cycle after enc_fin; res_len=16; enc_reset high exactly 1 cycle; state back to IDLE.
- Contention: req=4'b1111 held continuously -> grant order 0,1,2,3,0 with exactly one grant bit set at any time; each done matches its grant.
- Fairness after completion: req[2] held continuously, req[0] raised during req[2]'s transaction -> next grant goes to index 0 before index 2 is served again.
- Config stability: change req_src_port[0] from 16'h1234 to 16'hFFFF after grant -> enc_src_port stays 16'h1234 through CLEAR; res_checksum matches the reference model for 16'h1234.
- Timeout: TIMEOUT=16, requester never asserts data_av with len=4 -> err pulses 16 cycles after START ends; done never fires; enc_reset pulses; next requester is granted.
- Reset mid-STREAM: assert reset for 1 cycle -> grant=0 the next cycle, no done/err, enc_reset high, next req granted starting from index 0.
